// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension func3 encodings, mul/div FSM states, datapath width.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_DONE
  } muldiv_state_e;

  function automatic logic [XLEN-1:0] abs_if(input logic en, input logic [XLEN-1:0] v);
    return (en && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring unsigned divider datapath: one quotient bit per step, dividend shifts out of quo_q.
// The *_nxt outputs show the values the current step will register.
module div_core
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [XLEN:0]   shifted;

  // Partial remainder is always below the divisor, so the trial subtraction fits in XLEN bits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    if (shifted >= {1'b0, dvs_q}) begin
      rem_nxt_o = shifted[XLEN-1:0] - dvs_q;
      quo_nxt_o = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt_o = shifted[XLEN-1:0];
      quo_nxt_o = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      quo_q <= quo_nxt_o;
      rem_q <= rem_nxt_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M unit: 2-cycle multiply, 33-cycle divide, 1-cycle divide special cases.
// Stalls the front end until the result is registered; the result is held until the EX stage advances.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            advance,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  import cpu_pkg::*;

  localparam int unsigned CNT_W = $clog2(XLEN);

  muldiv_state_e     state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q, res_q, res_d;
  logic [1:0]        f3_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture, div_load, div_step, res_we;

  logic              in_div, in_signed, in_rem, in_special;
  logic [XLEN-1:0]   special_res;
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_ea, mul_eb, prod;
  logic [XLEN-1:0]   mul_res, div_res, quo_nxt, rem_nxt;
  logic              neg_q, neg_r;

  always_comb begin
    in_div    = func3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    in_signed = func3 inside {F3_DIV, F3_REM};
    in_rem    = func3 inside {F3_REM, F3_REMU};
    if (op_b == '0) begin
      in_special  = 1'b1;
      special_res = in_rem ? op_a : '1;
    end else begin
      in_special  = in_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
      special_res = in_rem ? '0 : op_a;
    end
  end

  always_comb begin
    mul_sa = 1'b0;
    mul_sb = 1'b0;
    case ({1'b0, f3_q})
      F3_MULH:          begin mul_sa = 1'b1; mul_sb = 1'b1; end
      F3_MULHSU:        mul_sa = 1'b1;
      F3_MUL, F3_MULHU: ;
      default:          ;
    endcase
    mul_ea  = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
    mul_eb  = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
    prod    = mul_ea * mul_eb;
    mul_res = ({1'b0, f3_q} == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // f3_q[0] marks the unsigned variants, f3_q[1] selects remainder over quotient.
  always_comb begin
    neg_q   = ~f3_q[0] & (a_q[XLEN-1] ^ b_q[XLEN-1]);
    neg_r   = ~f3_q[0] & a_q[XLEN-1];
    div_res = f3_q[1] ? (neg_r ? -rem_nxt : rem_nxt) : (neg_q ? -quo_nxt : quo_nxt);
  end

  div_core u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (abs_if(in_signed, op_a)),
    .divisor_i  (abs_if(in_signed, op_b)),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    capture   = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    res_we    = 1'b0;
    res_d     = res_q;
    case (state_q)
      MD_IDLE: if (start) begin
        stall_req = 1'b1;
        capture   = 1'b1;
        if (!in_div) begin
          state_d = MD_MUL;
        end else if (in_special) begin
          state_d = MD_DONE;
          res_we  = 1'b1;
          res_d   = special_res;
        end else begin
          state_d  = MD_DIV;
          div_load = 1'b1;
        end
      end
      MD_MUL: begin
        stall_req = 1'b1;
        res_we    = 1'b1;
        res_d     = mul_res;
        state_d   = MD_DONE;
      end
      MD_DIV: begin
        stall_req = 1'b1;
        div_step  = 1'b1;
        if (cnt_q == '0) begin
          res_we  = 1'b1;
          res_d   = div_res;
          state_d = MD_DONE;
        end
      end
      MD_DONE: if (advance) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    // Kill wins over everything; reset also keeps the stall low while it is held.
    if (flush || rst) begin
      state_d   = MD_IDLE;
      stall_req = 1'b0;
      capture   = 1'b0;
      div_load  = 1'b0;
      div_step  = 1'b0;
      res_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (capture) begin
        a_q  <= op_a;
        b_q  <= op_b;
        f3_q <= func3[1:0];
      end
      if (div_load)      cnt_q <= CNT_W'(XLEN - 1);
      else if (div_step) cnt_q <= cnt_q - 1'b1;
      if (res_we)        res_q <= res_d;
    end
  end

  assign result_valid = (state_q == MD_DONE);
  assign result       = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: results, stall lengths, hold, flush and reset behaviour.
module tb_ex_muldiv_unit;

  logic        clk, rst, start, flush, advance;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        stall_req, result_valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .flush        (flush),
    .advance      (advance),
    .func3        (func3),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Launch one op and count stall cycles until the result shows up; leaves the unit in DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_stall);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b1; func3 = f; op_a = a; op_b = b; advance = 1'b0;
    #1;
    while (stall_req && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
    chk({tag, "_vld"}, {31'b0, result_valid}, 32'd1);
    chk({tag, "_res"}, result, exp_res);
  endtask

  task automatic retire(input string tag);
    advance = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    #1;
    chk({tag, "_idle_vld"}, {31'b0, result_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; advance = 1'b0;
    func3 = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_vld", {31'b0, result_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    run_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);  retire("mul");
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);  retire("mulh");
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);  retire("mulhu");
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2);  retire("mulhsu");
    run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33); retire("div");
    run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33); retire("rem");
    run_op("divn",   3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33); retire("divn");
    run_op("remn",   3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33); retire("remn");
    run_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        33); retire("divu");
    run_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         33); retire("remu");
    run_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);  retire("divu0");
    run_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         1);  retire("remu0");
    run_op("rem0",   3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);  retire("rem0");
    run_op("divov",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);  retire("divov");
    run_op("remov",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Result must hold while the EX stage is stalled elsewhere.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_res", result, 32'd0);
      chk("hold_vld", {31'b0, result_valid}, 32'd1);
      chk("hold_stall", {31'b0, stall_req}, 32'd0);
    end
    retire("hold");

    // Flush on the 10th divide iteration.
    @(negedge clk);
    start = 1'b1; func3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    chk("pre_flush_stall", {31'b0, stall_req}, 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'b0, stall_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    chk("post_flush_vld", {31'b0, result_valid}, 32'd0);
    chk("post_flush_stall", {31'b0, stall_req}, 32'd0);
    run_op("after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33); retire("after_flush");

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; func3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_stall", {31'b0, stall_req}, 32'd0);
    chk("arst_vld", {31'b0, result_valid}, 32'd0);
    chk("arst_res", result, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'b100, 32'd1000, 32'd3, 32'd333, 33); retire("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It is fed by the ID/EX pipeline register: the is_mtype, func and forwarded rs1/rs2 data. It holds the pipeline through stall_req while it computes. It presents a 32-bit result to the EX result mux, and that result is held until the EX stage advances.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  EX instruction is a valid M-type op (EX_is_mtype, not a bubble)
flush  input  1  kill the in-flight operation (branch mispredict / trap)
advance  input  1  EX stage moves forward this cycle (IF_DONE & MEM_DONE & no other stall)
func3  input  3  M-op select
op_a  input  XLEN  forwarded rs1 data
op_b  input  XLEN  forwarded rs2 data
stall_req  output  1  freeze IF/ID/IDEX; result not ready
result_valid  output  1  result holds the final value
result  output  XLEN  M-op result

Behaviour:
- Reset (async): state IDLE; result=0, result_valid=0, internal operands, counters and quotient/remainder all 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=0: stall_req=0.
  - start=1: stall_req=1 (combinational); capture op_a, op_b, func3.
  - Next state is MUL for func3[2]=0.
  - Next state is DONE for the div special cases (divide-by-zero, signed overflow); the special result is registered directly.
  - Next state is DIV otherwise, with the iteration counter loaded to 31.
- MUL:
  - stall_req=1.
  - 64-bit product of the sign/zero-extended operands is registered (MUL=low word, MULH=high signed×signed, MULHSU=high signed×unsigned, MULHU=high unsigned×unsigned).
  - -> DONE. Total stall = 2 cycles.
- DIV:
  - stall_req=1.
  - Restoring divider on magnitudes: |op_a|, |op_b| for signed ops; raw values for DIVU/REMU. One quotient bit per cycle.
  - Counter decrements each cycle; the counter==0 cycle -> DONE. Total stall = 33 cycles.
- DONE:
  - stall_req=0, result_valid=1.
  - result is sign-corrected: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - result is stable every cycle while advance=0, including IF_DONE/MEM_DONE low for many cycles.
  - advance=1 -> IDLE.
- Special cases:
  - divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op_a.
  - op_a=0x80000000, op_b=0xFFFFFFFF (signed): DIV -> 0x80000000, REM -> 0.
  - Total stall = 1 cycle.
- flush=1 in any state:
  - Next state IDLE; result_valid=0 next cycle.
  - stall_req is forced 0 in the same cycle.
  - flush has priority over start and advance.
- Computation continues while memory stalls the pipeline; only flush or rst aborts it.
- start is ignored outside IDLE. The instruction in EX is constant while stall_req=1.
- After DONE+advance, the next cycle's start refers to the newly advanced instruction, so back-to-back M ops are legal.
- Mid-operation async rst returns the unit to IDLE immediately with all outputs 0.

Decomposition:
- Shared package (cpu_pkg):
  - func3 constants: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - muldiv_state_e enum.
  - XLEN constant.
- Sub-module: div_core.
  - Restoring iteration datapath holding quotient, remainder and divisor registers.
  - load/step controls come from the FSM.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD -> stall_req high 2 cycles; result=0xFFFFFFEB, result_valid=1.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD after 33 stall cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each with 1 stall cycle.
- DIV started, flush on iteration cycle 10 -> stall_req=0 that cycle, IDLE next cycle, result_valid=0. A following start runs a fresh 33-cycle op.
- DONE with advance=0 for 5 cycles -> result and result_valid unchanged, stall_req=0. Assert rst during DIV -> outputs 0 asynchronously.
